axi_write_arbiter: RTL and testbench
====================================

AXI_WRITE_ARBITER -- requirements
Module: axi_write_arbiter

Interface
REQ-001 Parameter ADDR_W, default 32, is the AW address width.
REQ-002 Parameter DATA_W, default 32, is the W data width; WSTRB width is DATA_W/8.
REQ-003 clk  in  1  is the single clock; all state updates on its rising edge.
REQ-004 rst_n  in  1  is the reset: synchronous and active-low.
REQ-005 boot_mode  in  1  when 1, only the bootloader master is eligible for grant.
REQ-006 cpu_awaddr/cpu_awvalid  in  ADDR_W/1, cpu_awready  out  1  is the CPU write-address channel.
REQ-007 cpu_wdata/cpu_wstrb/cpu_wvalid  in  DATA_W/DATA_W/8/1, cpu_wready  out  1  is the CPU write-data channel.
REQ-008 cpu_bresp/cpu_bvalid  out  2/1, cpu_bready  in  1  is the CPU write-response channel.
REQ-009 boot_aw*, boot_w*, boot_b* are identical in width and direction to REQ-006..008 for the bootloader master.
REQ-010 m_awaddr/m_awvalid  out, m_awready  in; m_wdata/m_wstrb/m_wvalid  out, m_wready  in; m_bresp/m_bvalid  in, m_bready  out form the interconnect-side master port.
REQ-011 grant  out  2  is a one-hot registered grant, bit0 = CPU, bit1 = bootloader, 00 when idle.
REQ-012 busy  out  1  is high whenever state is not IDLE.

Function
REQ-013 The FSM SHALL have states IDLE, ADDR and RESP, and SHALL arbitrate one complete write transaction (AW, W, B) at a time.
REQ-014 In IDLE, all upstream readies, upstream bvalids, m_awvalid, m_wvalid and m_bready SHALL be 0.
REQ-015 A master requests in IDLE by asserting awvalid; wvalid alone SHALL NOT be a request.
REQ-016 With boot_mode=1, only boot_awvalid SHALL be considered, and cpu_awvalid SHALL be ignored.
REQ-017 With boot_mode=0 and one requester, that master SHALL win; with both requesting, the master not granted last SHALL win (round-robin).
REQ-018 On a win, grant SHALL be set and the state SHALL move to ADDR on the next edge: one cycle of latency from upstream awvalid to m_awvalid.
REQ-019 In ADDR, the granted master's AW and W signals SHALL pass combinationally to m_*, and m_awready/m_wready SHALL pass back to it.
REQ-020 The non-granted master SHALL see awready=wready=bvalid=0 in every state.
REQ-021 Internal flags aw_done/w_done SHALL set on the respective m_ handshake; a done channel SHALL drive m_*valid=0 and upstream ready=0 until the transaction ends.
REQ-022 ADDR SHALL move to RESP on the edge where both flags are, or become, set; AW and W handshaking in the same cycle, or W before AW, are legal.
REQ-023 In RESP, m_bready SHALL equal the granted bready, and m_bvalid/m_bresp SHALL route to the granted master only.
REQ-024 On an m_bvalid&&m_bready handshake, the FSM SHALL return to IDLE, clear the flags, clear grant, and record the granted master as last-granted.
REQ-025 A change of boot_mode outside IDLE SHALL have no effect until the FSM returns to IDLE.
REQ-026 Address, data, strobe and bresp muxes SHALL select by the grant register; when grant=00 they SHALL select CPU, with all valids forced 0.
REQ-027 A new arbitration SHALL NOT occur in the cycle in which the B handshake completes; the earliest next grant is the following cycle.

Reset
REQ-028 While rst_n=0 at a clock edge, the state SHALL become IDLE, grant=00, busy=0, aw_done=w_done=0, and last-granted=bootloader, so that the CPU wins the first tie.
REQ-029 Reset asserted mid-transaction SHALL abandon the transaction, with no B response forwarded upstream.

Verification
REQ-030 After reset, boot_mode=0, CPU alone writes 0x1000/0xDEADBEEF -> grant=01 one cycle later, m_awaddr=0x1000, m_wdata=0xDEADBEEF, cpu_bvalid on m_bvalid, then grant=00.
REQ-031 boot_mode=0, both awvalid in the same cycle, three back-to-back writes each -> grant order CPU, BOOT, CPU, BOOT, CPU, BOOT.
REQ-032 boot_mode=1, both request -> only the bootloader is served, and cpu_awready stays 0 throughout.
REQ-033 Granted master presents W two cycles before AW, and the slave stalls m_bvalid 5 cycles -> one W handshake, one AW handshake, one B, busy high throughout, no duplicate valids.
REQ-034 rst_n=0 for one cycle while in RESP -> grant=00, busy=0 next cycle, no upstream bvalid, and the next tie goes to the CPU.
REQ-035 The bench SHALL check every cycle that the non-granted master's awready, wready and bvalid are 0.

Source files
------------

// File: rtl/axi_write_arbiter.sv
// Two-master AXI write arbiter (CPU, bootloader) onto one interconnect port.
// One full AW/W/B transaction is owned at a time; round-robin on ties, boot-only in boot_mode.
module axi_write_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                boot_mode,

    input  logic [ADDR_W-1:0]   cpu_awaddr,
    input  logic                cpu_awvalid,
    output logic                cpu_awready,
    input  logic [DATA_W-1:0]   cpu_wdata,
    input  logic [DATA_W/8-1:0] cpu_wstrb,
    input  logic                cpu_wvalid,
    output logic                cpu_wready,
    output logic [1:0]          cpu_bresp,
    output logic                cpu_bvalid,
    input  logic                cpu_bready,

    input  logic [ADDR_W-1:0]   boot_awaddr,
    input  logic                boot_awvalid,
    output logic                boot_awready,
    input  logic [DATA_W-1:0]   boot_wdata,
    input  logic [DATA_W/8-1:0] boot_wstrb,
    input  logic                boot_wvalid,
    output logic                boot_wready,
    output logic [1:0]          boot_bresp,
    output logic                boot_bvalid,
    input  logic                boot_bready,

    output logic [ADDR_W-1:0]   m_awaddr,
    output logic                m_awvalid,
    input  logic                m_awready,
    output logic [DATA_W-1:0]   m_wdata,
    output logic [DATA_W/8-1:0] m_wstrb,
    output logic                m_wvalid,
    input  logic                m_wready,
    input  logic [1:0]          m_bresp,
    input  logic                m_bvalid,
    output logic                m_bready,

    output logic [1:0]          grant,
    output logic                busy
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] ADDR = 2'd1;
    localparam logic [1:0] RESP = 2'd2;

    logic [1:0] state;
    logic       aw_done, w_done;
    logic       last_boot;

    logic sel_boot, in_addr, in_resp;
    logic cpu_req, boot_req, win_cpu, win_boot;
    logic aw_hs, w_hs, b_hs;

    assign sel_boot = grant[1];
    assign in_addr  = (state == ADDR);
    assign in_resp  = (state == RESP);
    assign busy     = (state != IDLE);

    // boot_mode masks the CPU out of arbitration only; it never touches a granted transaction
    assign cpu_req  = cpu_awvalid && !boot_mode;
    assign boot_req = boot_awvalid;
    assign win_cpu  = cpu_req && (!boot_req || last_boot);
    assign win_boot = boot_req && (!cpu_req || !last_boot);

    // Datapath selects by the grant register; grant=00 falls through to the CPU side
    assign m_awaddr  = sel_boot ? boot_awaddr : cpu_awaddr;
    assign m_wdata   = sel_boot ? boot_wdata  : cpu_wdata;
    assign m_wstrb   = sel_boot ? boot_wstrb  : cpu_wstrb;
    assign m_awvalid = in_addr && !aw_done && (sel_boot ? boot_awvalid : cpu_awvalid);
    assign m_wvalid  = in_addr && !w_done  && (sel_boot ? boot_wvalid  : cpu_wvalid);
    assign m_bready  = in_resp && (sel_boot ? boot_bready : cpu_bready);

    assign cpu_awready  = in_addr && grant[0] && !aw_done && m_awready;
    assign cpu_wready   = in_addr && grant[0] && !w_done  && m_wready;
    assign boot_awready = in_addr && grant[1] && !aw_done && m_awready;
    assign boot_wready  = in_addr && grant[1] && !w_done  && m_wready;

    assign cpu_bvalid  = in_resp && grant[0] && m_bvalid;
    assign boot_bvalid = in_resp && grant[1] && m_bvalid;
    assign cpu_bresp   = grant[0] ? m_bresp : 2'b00;
    assign boot_bresp  = grant[1] ? m_bresp : 2'b00;

    assign aw_hs = m_awvalid && m_awready;
    assign w_hs  = m_wvalid && m_wready;
    assign b_hs  = m_bvalid && m_bready;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            grant     <= 2'b00;
            aw_done   <= 1'b0;
            w_done    <= 1'b0;
            last_boot <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (win_cpu || win_boot) begin
                        grant <= {win_boot, win_cpu};
                        state <= ADDR;
                    end
                end
                ADDR: begin
                    if (aw_hs) aw_done <= 1'b1;
                    if (w_hs)  w_done  <= 1'b1;
                    if ((aw_done || aw_hs) && (w_done || w_hs)) state <= RESP;
                end
                RESP: begin
                    // Back to IDLE only; re-arbitration waits for the next cycle
                    if (b_hs) begin
                        state     <= IDLE;
                        grant     <= 2'b00;
                        aw_done   <= 1'b0;
                        w_done    <= 1'b0;
                        last_boot <= grant[1];
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_axi_write_arbiter.sv
// Directed bench for axi_write_arbiter: a table of single transactions plus
// hand sequences for W-before-AW with B stall, boot-mode lockout and mid-response reset.
module tb_axi_write_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        boot_mode;
    logic [31:0] cpu_awaddr, boot_awaddr, m_awaddr;
    logic        cpu_awvalid, cpu_awready, boot_awvalid, boot_awready, m_awvalid, m_awready;
    logic [31:0] cpu_wdata, boot_wdata, m_wdata;
    logic [3:0]  cpu_wstrb, boot_wstrb, m_wstrb;
    logic        cpu_wvalid, cpu_wready, boot_wvalid, boot_wready, m_wvalid, m_wready;
    logic [1:0]  cpu_bresp, boot_bresp, m_bresp;
    logic        cpu_bvalid, cpu_bready, boot_bvalid, boot_bready, m_bvalid, m_bready;
    logic [1:0]  grant;
    logic        busy;

    always #5 clk = ~clk;

    axi_write_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk(clk), .rst_n(rst_n), .boot_mode(boot_mode),
        .cpu_awaddr(cpu_awaddr), .cpu_awvalid(cpu_awvalid), .cpu_awready(cpu_awready),
        .cpu_wdata(cpu_wdata), .cpu_wstrb(cpu_wstrb), .cpu_wvalid(cpu_wvalid), .cpu_wready(cpu_wready),
        .cpu_bresp(cpu_bresp), .cpu_bvalid(cpu_bvalid), .cpu_bready(cpu_bready),
        .boot_awaddr(boot_awaddr), .boot_awvalid(boot_awvalid), .boot_awready(boot_awready),
        .boot_wdata(boot_wdata), .boot_wstrb(boot_wstrb), .boot_wvalid(boot_wvalid), .boot_wready(boot_wready),
        .boot_bresp(boot_bresp), .boot_bvalid(boot_bvalid), .boot_bready(boot_bready),
        .m_awaddr(m_awaddr), .m_awvalid(m_awvalid), .m_awready(m_awready),
        .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wvalid(m_wvalid), .m_wready(m_wready),
        .m_bresp(m_bresp), .m_bvalid(m_bvalid), .m_bready(m_bready),
        .grant(grant), .busy(busy)
    );

    int n_vec = 0;
    int n_err = 0;
    logic [1:0] exp_gnt = 2'b00;
    logic mon_en = 1'b0;
    int aw_cnt = 0, w_cnt = 0, b_cnt = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Non-granted master must stay silent every cycle; idle must keep the master port quiet
    always @(negedge clk) begin
        if (mon_en) begin
            if (!exp_gnt[0]) begin
                chk("mon_cpu_awready", 32'(cpu_awready), 0);
                chk("mon_cpu_wready",  32'(cpu_wready),  0);
                chk("mon_cpu_bvalid",  32'(cpu_bvalid),  0);
            end
            if (!exp_gnt[1]) begin
                chk("mon_boot_awready", 32'(boot_awready), 0);
                chk("mon_boot_wready",  32'(boot_wready),  0);
                chk("mon_boot_bvalid",  32'(boot_bvalid),  0);
            end
            if (exp_gnt == 2'b00) begin
                chk("mon_idle_m_awvalid", 32'(m_awvalid), 0);
                chk("mon_idle_m_wvalid",  32'(m_wvalid),  0);
                chk("mon_idle_m_bready",  32'(m_bready),  0);
            end
        end
    end

    always @(posedge clk) begin
        if (m_awvalid && m_awready) aw_cnt++;
        if (m_wvalid && m_wready)   w_cnt++;
        if (m_bvalid && m_bready)   b_cnt++;
    end

    typedef struct {
        logic        bm, creq, breq, flip;
        logic [1:0]  resp, exp_g;
        logic [31:0] caddr, cdata, baddr, bdata;
    } vec_t;

    vec_t vt [12];

    task automatic idle_inputs();
        cpu_awvalid = 0; cpu_wvalid = 0; boot_awvalid = 0; boot_wvalid = 0;
        m_awready = 0; m_wready = 0; m_bvalid = 0; m_bresp = 2'b00;
    endtask

    task automatic do_xact(input vec_t v, input int idx);
        logic [31:0] ea, ed;
        logic [3:0]  es;
        string       tg;
        tg = $sformatf("v%0d", idx);
        ea = v.exp_g[1] ? v.baddr : v.caddr;
        ed = v.exp_g[1] ? v.bdata : v.cdata;
        es = v.exp_g[1] ? 4'h3 : 4'hF;
        boot_mode = v.bm;
        cpu_awaddr = v.caddr; cpu_wdata = v.cdata; cpu_awvalid = v.creq; cpu_wvalid = v.creq;
        boot_awaddr = v.baddr; boot_wdata = v.bdata; boot_awvalid = v.breq; boot_wvalid = v.breq;
        #1;
        chk({tg, "_lat_awvalid"}, 32'(m_awvalid), 0);
        tick();
        exp_gnt = v.exp_g;
        if (v.flip) boot_mode = !v.bm;
        chk({tg, "_grant"},   32'(grant), 32'(v.exp_g));
        chk({tg, "_busy"},    32'(busy), 1);
        chk({tg, "_awvalid"}, 32'(m_awvalid), 1);
        chk({tg, "_wvalid"},  32'(m_wvalid), 1);
        chk({tg, "_awaddr"},  m_awaddr, ea);
        chk({tg, "_wdata"},   m_wdata, ed);
        chk({tg, "_wstrb"},   32'(m_wstrb), 32'(es));
        m_awready = 1; m_wready = 1;
        #1;
        chk({tg, "_awready"}, 32'(v.exp_g[1] ? boot_awready : cpu_awready), 1);
        chk({tg, "_wready"},  32'(v.exp_g[1] ? boot_wready : cpu_wready), 1);
        tick();
        m_awready = 0; m_wready = 0;
        if (v.exp_g[1]) begin boot_awvalid = 0; boot_wvalid = 0; end
        else begin cpu_awvalid = 0; cpu_wvalid = 0; end
        m_bvalid = 1; m_bresp = v.resp;
        #1;
        chk({tg, "_resp_busy"}, 32'(busy), 1);
        chk({tg, "_bvalid"}, 32'(v.exp_g[1] ? boot_bvalid : cpu_bvalid), 1);
        chk({tg, "_bresp"},  32'(v.exp_g[1] ? boot_bresp : cpu_bresp), 32'(v.resp));
        chk({tg, "_bready"}, 32'(m_bready), 1);
        tick();
        exp_gnt = 2'b00;
        idle_inputs();
        #1;
        chk({tg, "_end_grant"}, 32'(grant), 0);
        chk({tg, "_end_busy"},  32'(busy), 0);
    endtask

    initial begin
        //         bm creq breq flip resp  exp_g  caddr          cdata          baddr          bdata
        vt[0]  = '{0, 1, 0, 0, 2'd0, 2'b01, 32'h0000_1000, 32'hDEAD_BEEF, 32'h8000_0000, 32'h1111_0000};
        vt[1]  = '{0, 0, 1, 0, 2'd1, 2'b10, 32'h0000_1010, 32'hC0DE_0001, 32'h8000_0010, 32'h1111_0001};
        vt[2]  = '{0, 1, 1, 0, 2'd0, 2'b01, 32'h0000_1020, 32'hC0DE_0002, 32'h8000_0020, 32'h1111_0002};
        vt[3]  = '{0, 1, 1, 0, 2'd2, 2'b10, 32'h0000_1030, 32'hC0DE_0003, 32'h8000_0030, 32'h1111_0003};
        vt[4]  = '{0, 1, 1, 0, 2'd3, 2'b01, 32'h0000_1040, 32'hC0DE_0004, 32'h8000_0040, 32'h1111_0004};
        vt[5]  = '{0, 1, 1, 0, 2'd1, 2'b10, 32'h0000_1050, 32'hC0DE_0005, 32'h8000_0050, 32'h1111_0005};
        vt[6]  = '{0, 1, 1, 0, 2'd0, 2'b01, 32'h0000_1060, 32'hC0DE_0006, 32'h8000_0060, 32'h1111_0006};
        vt[7]  = '{0, 1, 1, 0, 2'd2, 2'b10, 32'h0000_1070, 32'hC0DE_0007, 32'h8000_0070, 32'h1111_0007};
        vt[8]  = '{1, 1, 1, 0, 2'd1, 2'b10, 32'h0000_1080, 32'hC0DE_0008, 32'h8000_0080, 32'h1111_0008};
        vt[9]  = '{1, 1, 1, 0, 2'd3, 2'b10, 32'h0000_1090, 32'hC0DE_0009, 32'h8000_0090, 32'h1111_0009};
        vt[10] = '{0, 1, 0, 1, 2'd2, 2'b01, 32'h0000_10A0, 32'hC0DE_000A, 32'h8000_00A0, 32'h1111_000A};
        vt[11] = '{0, 0, 1, 0, 2'd0, 2'b10, 32'h0000_10B0, 32'hC0DE_000B, 32'h8000_00B0, 32'h1111_000B};

        rst_n = 0; boot_mode = 0;
        cpu_awaddr = 0; cpu_wdata = 0; cpu_wstrb = 4'hF; cpu_bready = 1;
        boot_awaddr = 0; boot_wdata = 0; boot_wstrb = 4'h3; boot_bready = 1;
        idle_inputs();
        tick(); tick();
        chk("rst_grant", 32'(grant), 0);
        chk("rst_busy",  32'(busy), 0);
        chk("rst_m_awvalid", 32'(m_awvalid), 0);
        rst_n = 1;
        mon_en = 1;

        for (int i = 0; i < 12; i++) do_xact(vt[i], i);

        // Boot mode: a lone CPU request is never granted
        boot_mode = 1; cpu_awvalid = 1; cpu_wvalid = 1; cpu_awaddr = 32'h2000;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("bm_cpu_grant", 32'(grant), 0);
            chk("bm_cpu_awready", 32'(cpu_awready), 0);
        end
        idle_inputs(); boot_mode = 0;
        tick();

        // W two cycles ahead of AW (not a request), W accepted before AW, B stalled 5 cycles
        aw_cnt = 0; w_cnt = 0; b_cnt = 0;
        cpu_wvalid = 1; cpu_wdata = 32'hA5A5_0001; cpu_awaddr = 32'h3000;
        tick(); chk("wonly_grant0", 32'(grant), 0);
        tick(); chk("wonly_grant1", 32'(grant), 0);
        cpu_awvalid = 1;
        tick();
        exp_gnt = 2'b01;
        chk("wfirst_grant", 32'(grant), 1);
        m_wready = 1;
        #1; chk("wfirst_wready", 32'(cpu_wready), 1);
        chk("wfirst_awaddr", m_awaddr, 32'h3000);
        tick();
        chk("wdone_m_wvalid", 32'(m_wvalid), 0);
        chk("wdone_cpu_wready", 32'(cpu_wready), 0);
        chk("wdone_busy", 32'(busy), 1);
        cpu_wvalid = 0; m_wready = 0; m_awready = 1;
        #1; chk("awlate_awvalid", 32'(m_awvalid), 1);
        tick();
        cpu_awvalid = 0; m_awready = 0;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("stall_busy", 32'(busy), 1);
            chk("stall_bvalid", 32'(cpu_bvalid), 0);
            chk("stall_m_awvalid", 32'(m_awvalid), 0);
            chk("stall_m_wvalid", 32'(m_wvalid), 0);
            tick();
        end
        m_bvalid = 1; m_bresp = 2'b01;
        #1;
        chk("stall_b_bvalid", 32'(cpu_bvalid), 1);
        chk("stall_b_bresp", 32'(cpu_bresp), 1);
        tick();
        exp_gnt = 2'b00;
        idle_inputs();
        #1;
        chk("stall_end_busy", 32'(busy), 0);
        chk("stall_aw_cnt", 32'(aw_cnt), 1);
        chk("stall_w_cnt",  32'(w_cnt), 1);
        chk("stall_b_cnt",  32'(b_cnt), 1);

        // Reset during RESP after a CPU win: transaction dropped, CPU wins the next tie
        cpu_awvalid = 1; cpu_wvalid = 1; cpu_awaddr = 32'h4000;
        tick();
        exp_gnt = 2'b01;
        chk("rr_grant", 32'(grant), 1);
        m_awready = 1; m_wready = 1;
        tick();
        idle_inputs();
        rst_n = 0;
        tick();
        rst_n = 1;
        exp_gnt = 2'b00;
        m_bvalid = 1;
        #1;
        chk("rr_grant_after", 32'(grant), 0);
        chk("rr_busy_after", 32'(busy), 0);
        chk("rr_cpu_bvalid", 32'(cpu_bvalid), 0);
        chk("rr_boot_bvalid", 32'(boot_bvalid), 0);
        idle_inputs();
        tick();
        do_xact('{0, 1, 1, 0, 2'd0, 2'b01, 32'h0000_5000, 32'hFACE_0001, 32'h8000_5000, 32'hFACE_0002}, 99);

        mon_en = 0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
